// File: rtl/receivers_pkg.sv
// Shared constants and helpers for the lighthouse receiver datapath.
// FIFO entries are packed MSB to LSB as {channel, data, timestamp}.
package receivers_pkg;

  localparam int unsigned DATA_WIDTH = 17;
  localparam int unsigned TS_WIDTH   = 24;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned entry_width(input int unsigned ch_w, input int unsigned d_w,
                                              input int unsigned ts_w);
    return ch_w + d_w + ts_w;
  endfunction

endpackage

// File: rtl/multi_receiver_collector_if.sv
// Tagged result stream from the collector to the downstream transmit logic.
interface multi_receiver_collector_if #(
  parameter int unsigned DATA_WIDTH = receivers_pkg::DATA_WIDTH,
  parameter int unsigned TS_WIDTH   = receivers_pkg::TS_WIDTH,
  parameter int unsigned CH_WIDTH   = 2
);

  logic                  out_valid;
  logic                  out_ready;
  logic [CH_WIDTH-1:0]   out_channel;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TS_WIDTH-1:0]   out_timestamp;

  modport master (
    output out_valid,
    output out_channel,
    output out_data,
    output out_timestamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_channel,
    input  out_data,
    input  out_timestamp,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; push while full is accepted only with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_96MHz,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FullLevel);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero while empty so the outputs are deterministic after reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/multi_receiver_collector.sv
// Collects per-channel receiver results, arbitrates them round-robin into a shared FIFO
// and owns the free-running system timestamp.
module multi_receiver_collector #(
  parameter int unsigned N_RECEIVERS = 4,
  parameter int unsigned DATA_WIDTH  = receivers_pkg::DATA_WIDTH,
  parameter int unsigned TS_WIDTH    = receivers_pkg::TS_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CH_WIDTH    = receivers_pkg::ch_width(N_RECEIVERS)
) (
  input  logic                              clk_96MHz,
  input  logic                              reset_n,
  output logic [TS_WIDTH-1:0]               system_timestamp,
  input  logic [N_RECEIVERS-1:0]            channel_enable,
  input  logic [N_RECEIVERS-1:0]            data_availible,
  input  logic [N_RECEIVERS*DATA_WIDTH-1:0] decoded_data,
  input  logic [N_RECEIVERS*TS_WIDTH-1:0]   timestamp_last_data,
  multi_receiver_collector_if.master        stream,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [N_RECEIVERS-1:0]            overrun_flags,
  output logic [15:0]                       drop_count,
  input  logic                              clear_flags
);

  localparam int unsigned EntryWidth =
      receivers_pkg::entry_width(CH_WIDTH, DATA_WIDTH, TS_WIDTH);
  localparam logic [CH_WIDTH:0] NExt = (CH_WIDTH + 1)'(N_RECEIVERS);

  logic [TS_WIDTH-1:0]    ts_q;
  logic [N_RECEIVERS-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0]  hold_data_q [N_RECEIVERS];
  logic [TS_WIDTH-1:0]    hold_ts_q [N_RECEIVERS];
  logic [CH_WIDTH-1:0]    last_grant_q;
  logic [N_RECEIVERS-1:0] overrun_flags_q, overrun_flags_d;
  logic [15:0]            drop_count_q, drop_count_d, drop_base;
  logic [16:0]            drop_sum;
  logic [4:0]             n_over;

  logic [N_RECEIVERS-1:0] capture, granted, overrun;
  logic                   grant_valid;
  logic [CH_WIDTH-1:0]    grant_idx;
  logic [CH_WIDTH:0]      cand;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
  logic [EntryWidth-1:0]  push_data, pop_data;

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + TS_WIDTH'(1);
  end

  assign system_timestamp = ts_q;
  assign capture          = data_availible & channel_enable;

  assign fifo_pop = !fifo_empty && stream.out_ready;
  assign can_push = !fifo_full || fifo_pop;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_RECEIVERS; k++) begin
      cand = {1'b0, last_grant_q} + (CH_WIDTH + 1)'(k);
      if (cand >= NExt) cand = cand - NExt;
      if (!grant_valid && can_push && pending_q[cand[CH_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[CH_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    granted = '0;
    if (grant_valid) granted[grant_idx] = 1'b1;
  end

  // A capture on a channel granted this edge refills it without counting as a loss.
  assign overrun   = capture & pending_q & ~granted;
  assign pending_d = capture | (pending_q & ~granted);

  always_comb begin
    n_over = '0;
    for (int unsigned i = 0; i < N_RECEIVERS; i++) begin
      n_over = n_over + 5'(overrun[i]);
    end
    drop_base       = clear_flags ? 16'h0000 : drop_count_q;
    drop_sum        = {1'b0, drop_base} + 17'(n_over);
    drop_count_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overrun_flags_d = (clear_flags ? '0 : overrun_flags_q) | overrun;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      pending_q       <= '0;
      last_grant_q    <= CH_WIDTH'(N_RECEIVERS - 1);
      overrun_flags_q <= '0;
      drop_count_q    <= '0;
    end else begin
      pending_q       <= pending_d;
      overrun_flags_q <= overrun_flags_d;
      drop_count_q    <= drop_count_d;
      if (grant_valid) last_grant_q <= grant_idx;
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_RECEIVERS; i++) begin
        hold_data_q[i] <= '0;
        hold_ts_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_RECEIVERS; i++) begin
        if (capture[i]) begin
          hold_data_q[i] <= decoded_data[i*DATA_WIDTH +: DATA_WIDTH];
          hold_ts_q[i]   <= timestamp_last_data[i*TS_WIDTH +: TS_WIDTH];
        end
      end
    end
  end

  assign fifo_push = grant_valid;
  assign push_data = {grant_idx, hold_data_q[grant_idx], hold_ts_q[grant_idx]};

  sync_fifo #(
    .WIDTH (EntryWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_96MHz (clk_96MHz),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign stream.out_valid     = !fifo_empty;
  assign stream.out_channel   = pop_data[EntryWidth-1 -: CH_WIDTH];
  assign stream.out_data      = pop_data[TS_WIDTH +: DATA_WIDTH];
  assign stream.out_timestamp = pop_data[TS_WIDTH-1:0];
  assign overrun_flags        = overrun_flags_q;
  assign drop_count           = drop_count_q;

endmodule

// File: tb/tb_multi_receiver_collector.sv
// Directed and randomized bench for multi_receiver_collector against a queue-based model.
module tb_multi_receiver_collector;

  localparam int N     = 4;
  localparam int DW    = 17;
  localparam int TW    = 24;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } ent_t;

  logic            clk_96MHz = 1'b0;
  logic            reset_n;
  logic [TW-1:0]   system_timestamp;
  logic [N-1:0]    channel_enable, data_availible;
  logic [N*DW-1:0] decoded_data;
  logic [N*TW-1:0] timestamp_last_data;
  logic [4:0]      fifo_level;
  logic [N-1:0]    overrun_flags;
  logic [15:0]     drop_count;
  logic            clear_flags;

  logic [3:0]      small_ts;
  logic [1:0]      small_level, small_flags;
  logic [15:0]     small_drop;
  logic [1:0]      small_zero2 = 2'b00;
  logic [2*DW-1:0] small_data  = '0;
  logic [7:0]      small_tsin  = '0;
  logic            small_clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  multi_receiver_collector_if #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .CH_WIDTH(2)) stream_if ();
  multi_receiver_collector_if #(.DATA_WIDTH(DW), .TS_WIDTH(4), .CH_WIDTH(1)) small_if ();

  multi_receiver_collector #(
    .N_RECEIVERS (N), .DATA_WIDTH (DW), .TS_WIDTH (TW), .FIFO_DEPTH (DEPTH), .CH_WIDTH (2)
  ) dut (
    .clk_96MHz           (clk_96MHz),
    .reset_n             (reset_n),
    .system_timestamp    (system_timestamp),
    .channel_enable      (channel_enable),
    .data_availible      (data_availible),
    .decoded_data        (decoded_data),
    .timestamp_last_data (timestamp_last_data),
    .stream              (stream_if),
    .fifo_level          (fifo_level),
    .overrun_flags       (overrun_flags),
    .drop_count          (drop_count),
    .clear_flags         (clear_flags)
  );

  // Narrow-timestamp instance so counter wrap is reachable in a short run.
  multi_receiver_collector #(
    .N_RECEIVERS (2), .DATA_WIDTH (DW), .TS_WIDTH (4), .FIFO_DEPTH (2), .CH_WIDTH (1)
  ) dut_small (
    .clk_96MHz           (clk_96MHz),
    .reset_n             (reset_n),
    .system_timestamp    (small_ts),
    .channel_enable      (small_zero2),
    .data_availible      (small_zero2),
    .decoded_data        (small_data),
    .timestamp_last_data (small_tsin),
    .stream              (small_if),
    .fifo_level          (small_level),
    .overrun_flags       (small_flags),
    .drop_count          (small_drop),
    .clear_flags         (small_clear)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  // Reference model state
  logic [TW-1:0] m_ts;
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_hd [N];
  logic [TW-1:0] m_ht [N];
  ent_t          m_q [$];
  int            m_last;
  logic [N-1:0]  m_flags;
  int            m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ts = '0; m_pend = '0; m_q.delete(); m_last = N - 1; m_flags = '0; m_drop = 0;
    for (int i = 0; i < N; i++) begin m_hd[i] = '0; m_ht[i] = '0; end
  endtask

  task automatic model_edge();
    bit           pop;
    int           g;
    logic [N-1:0] ovm;
    ent_t         e;
    if (!reset_n) begin model_reset(); return; end
    pop = (m_q.size() > 0) && (stream_if.out_ready === 1'b1);
    g = -1;
    if (m_q.size() < DEPTH || pop)
      for (int k = 1; k <= N; k++)
        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
    ovm = '0;
    for (int i = 0; i < N; i++)
      if (data_availible[i] && channel_enable[i] && m_pend[i] && g != i) ovm[i] = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      e.ch = 2'(g); e.d = m_hd[g]; e.t = m_ht[g];
      m_q.push_back(e);
      m_pend[g] = 1'b0;
      m_last = g;
    end
    for (int i = 0; i < N; i++)
      if (data_availible[i] && channel_enable[i]) begin
        m_hd[i] = decoded_data[i*DW +: DW];
        m_ht[i] = timestamp_last_data[i*TW +: TW];
        m_pend[i] = 1'b1;
      end
    if (clear_flags) begin m_flags = '0; m_drop = 0; end
    m_flags = m_flags | ovm;
    m_drop = m_drop + $countones(ovm);
    if (m_drop > 65535) m_drop = 65535;
    m_ts = m_ts + 1'b1;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(stream_if.out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_channel", 64'(stream_if.out_channel), 64'(m_q[0].ch));
      chk("out_data", 64'(stream_if.out_data), 64'(m_q[0].d));
      chk("out_timestamp", 64'(stream_if.out_timestamp), 64'(m_q[0].t));
    end
    chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    chk("overrun_flags", 64'(overrun_flags), 64'(m_flags));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("system_timestamp", 64'(system_timestamp), 64'(m_ts));
    chk("small_ts", 64'(small_ts), 64'(m_ts[3:0]));
    chk("small_idle", 64'({small_if.out_valid, small_level, small_flags, small_drop}), 64'(0));
  endtask

  task automatic cycle();
    @(posedge clk_96MHz);
    model_edge();
    @(negedge clk_96MHz);
    check_all();
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
    decoded_data[i*DW +: DW]        = d;
    timestamp_last_data[i*TW +: TW] = t;
  endtask

  task automatic strobe(input logic [N-1:0] mask);
    data_availible = mask;
    cycle();
    data_availible = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    got [$];
    logic [DW-1:0] last_d;
    int            npop;
    bit            found;

    reset_n = 1'b0; channel_enable = '1; data_availible = '0; clear_flags = 1'b0;
    decoded_data = '0; timestamp_last_data = '0;
    stream_if.out_ready = 1'b1; small_if.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_96MHz);
    check_all();
    chk("rst_out_fields", 64'({stream_if.out_channel, stream_if.out_data,
                               stream_if.out_timestamp}), 64'(0));
    reset_n = 1'b1;

    // All four channels at once, twice: drain order 0..3 each time.
    for (int i = 0; i < N; i++) set_ch(i, DW'(17'h100 + i), TW'(24'h10 + i));
    for (int r = 0; r < 2; r++) begin
      got.delete();
      strobe(4'hF);
      for (int c = 0; c < 8; c++) begin
        if (stream_if.out_valid) got.push_back(stream_if.out_channel);
        cycle();
      end
      chk("rr_count", 64'(got.size()), 64'(4));
      for (int j = 0; j < got.size(); j++) chk("rr_order", 64'(got[j]), 64'(j));
    end

    // Single channel latency.
    set_ch(2, 17'h1ABCD, 24'h000100);
    strobe(4'b0100);
    chk("lat_not_yet", 64'(stream_if.out_valid), 64'(0));
    cycle();
    chk("lat_valid", 64'(stream_if.out_valid), 64'(1));
    chk("lat_channel", 64'(stream_if.out_channel), 64'(2));
    chk("lat_data", 64'(stream_if.out_data), 64'(17'h1ABCD));
    chk("lat_ts", 64'(stream_if.out_timestamp), 64'(24'h000100));
    chk("lat_level", 64'(fifo_level), 64'(1));
    cycle();

    // Fill with consumer stalled, then overrun the held 17th entry.
    stream_if.out_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      set_ch(0, DW'(17'h200 + k), TW'(k));
      strobe(4'b0001);
      if (k == 16) chk("full_level", 64'(fifo_level), 64'(16));
    end
    chk("ovr_flag", 64'(overrun_flags), 64'(4'b0001));
    chk("ovr_drop", 64'(drop_count), 64'(1));
    stream_if.out_ready = 1'b1;
    npop = 0; last_d = '0;
    for (int c = 0; c < 40; c++) begin
      if (stream_if.out_valid) begin npop++; last_d = stream_if.out_data; end
      cycle();
    end
    chk("drain_count", 64'(npop), 64'(17));
    chk("drain_newest", 64'(last_d), 64'(17'h211));

    // Disabled channel strobe is ignored.
    channel_enable = 4'b1110;
    set_ch(0, 17'h0AAAA, 24'h00AAAA);
    strobe(4'b0001);
    cycle();
    chk("dis_level", 64'(fifo_level), 64'(0));
    chk("dis_flags", 64'(overrun_flags), 64'(4'b0001));
    channel_enable = 4'hF;

    // Clear at the same edge as a ch1 overrun: overrun wins.
    strobe(4'b0010);
    cycle();
    strobe(4'b0110);
    clear_flags = 1'b1;
    strobe(4'b0010);
    clear_flags = 1'b0;
    chk("clr_ovr_flags", 64'(overrun_flags), 64'(4'b0010));
    chk("clr_ovr_drop", 64'(drop_count), 64'(1));
    repeat (4) cycle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      channel_enable      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      data_availible      = 4'($urandom) & 4'($urandom);
      decoded_data        = {$urandom, $urandom, $urandom};
      timestamp_last_data = {$urandom, $urandom, $urandom};
      stream_if.out_ready = (c % 100 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clear_flags         = ($urandom_range(0, 49) == 0);
      cycle();
    end
    data_availible = '0; clear_flags = 1'b0; channel_enable = '1; stream_if.out_ready = 1'b1;
    repeat (24) cycle();

    // Asynchronous reset with 5 queued and 2 pending.
    stream_if.out_ready = 1'b0;
    strobe(4'hF);
    repeat (4) cycle();
    strobe(4'b0111);
    cycle();
    chk("pre_rst_level", 64'(fifo_level), 64'(5));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(stream_if.out_valid), 64'(0));
    chk("arst_level", 64'(fifo_level), 64'(0));
    chk("arst_ts", 64'(system_timestamp), 64'(0));
    model_reset();
    cycle();
    reset_n = 1'b1;
    stream_if.out_ready = 1'b1;
    strobe(4'hF);
    cycle();
    chk("post_rst_first", 64'(stream_if.out_channel), 64'(0));
    repeat (6) cycle();

    // Timestamp wrap on the narrow instance.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (small_ts == 4'hE) found = 1'b1;
      else cycle();
    end
    chk("wrap_reach", 64'(found), 64'(1));
    if (found) begin
      cycle(); chk("wrap_f", 64'(small_ts), 64'(4'hF));
      cycle(); chk("wrap_0", 64'(small_ts), 64'(4'h0));
      cycle(); chk("wrap_1", 64'(small_ts), 64'(4'h1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
